// File: rtl/control_idex_if.sv
// ID-stage control handshake: instruction fields in, pipeline control and ID/EX register contents out.
interface control_idex_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  enable;
    logic                  flush;
    logic [5:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  id_jump;

    logic                  ex_reg_dst;
    logic                  ex_branch;
    logic                  ex_branch_ne;
    logic                  ex_mem_read;
    logic                  ex_mem_to_reg;
    logic                  ex_mem_write;
    logic                  ex_alu_src;
    logic                  ex_reg_write;
    logic [1:0]            ex_alu_op;
    logic                  ex_illegal;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output enable, flush, id_opcode, id_rs, id_rt, id_rd,
        input  pc_write, ifid_write, ifid_flush, id_jump,
        input  ex_reg_dst, ex_branch, ex_branch_ne, ex_mem_read, ex_mem_to_reg,
        input  ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_illegal,
        input  ex_rs, ex_rt, ex_rd, stall_cnt
    );

    modport slave (
        input  enable, flush, id_opcode, id_rs, id_rt, id_rd,
        output pc_write, ifid_write, ifid_flush, id_jump,
        output ex_reg_dst, ex_branch, ex_branch_ne, ex_mem_read, ex_mem_to_reg,
        output ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_illegal,
        output ex_rs, ex_rt, ex_rd, stall_cnt
    );
endinterface

// File: rtl/control_idex.sv
// Pipelined MIPS main control: ID decode into the ID/EX register, load-use stall
// insertion, branch flush handling, optional BNE/ADDI/J, and a stall-cycle counter.
module control_idex #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ENABLE_EXT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    control_idex_if.slave bus
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam bit EXT_ON = (ENABLE_EXT != 0);

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t                 dec_ctrl;
    logic                  dec_illegal;
    logic                  dec_jump;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  stall_c;

    ctrl_t                 ex_ctrl_d,    ex_ctrl_q;
    logic                  ex_illegal_d, ex_illegal_q;
    logic [REG_ADDR_W-1:0] ex_rs_d,      ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_d,      ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_rd_d,      ex_rd_q;
    logic [CNT_W-1:0]      stall_cnt_d,  stall_cnt_q;

    logic                  pc_write_c;
    logic                  ifid_write_c;
    logic                  ifid_flush_c;
    logic                  id_jump_c;

    // Opcode decode; an invalid ID slot decodes as a bubble with no register reads
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        dec_jump    = 1'b0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        if (bus.enable) begin
            unique case (bus.id_opcode)
                OP_R: begin
                    dec_ctrl.reg_dst   = 1'b1;
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_op    = ALU_FUNCT;
                    uses_rs            = 1'b1;
                    uses_rt            = 1'b1;
                end
                OP_LW: begin
                    dec_ctrl.mem_read   = 1'b1;
                    dec_ctrl.mem_to_reg = 1'b1;
                    dec_ctrl.alu_src    = 1'b1;
                    dec_ctrl.reg_write  = 1'b1;
                    dec_ctrl.alu_op     = ALU_ADD;
                    uses_rs             = 1'b1;
                end
                OP_SW: begin
                    dec_ctrl.mem_write = 1'b1;
                    dec_ctrl.alu_src   = 1'b1;
                    dec_ctrl.alu_op    = ALU_ADD;
                    uses_rs            = 1'b1;
                    uses_rt            = 1'b1;
                end
                OP_BEQ: begin
                    dec_ctrl.branch = 1'b1;
                    dec_ctrl.alu_op = ALU_SUB;
                    uses_rs         = 1'b1;
                    uses_rt         = 1'b1;
                end
                OP_BNE: begin
                    if (EXT_ON) begin
                        dec_ctrl.branch    = 1'b1;
                        dec_ctrl.branch_ne = 1'b1;
                        dec_ctrl.alu_op    = ALU_SUB;
                        uses_rs            = 1'b1;
                        uses_rt            = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_ADDI: begin
                    if (EXT_ON) begin
                        dec_ctrl.alu_src   = 1'b1;
                        dec_ctrl.reg_write = 1'b1;
                        dec_ctrl.alu_op    = ALU_ADD;
                        uses_rs            = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_J: begin
                    if (EXT_ON) begin
                        dec_jump = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Load-use hazard: $zero as the load target is never a real dependency
    always_comb begin
        stall_c = bus.enable & ~bus.flush & ex_ctrl_q.mem_read &
                  (ex_rt_q != '0) &
                  ((uses_rs & (ex_rt_q == bus.id_rs)) |
                   (uses_rt & (ex_rt_q == bus.id_rt)));
    end

    // Next-state and pipeline control; flush beats stall, stall beats normal issue
    always_comb begin
        ex_ctrl_d    = '0;
        ex_illegal_d = 1'b0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        stall_cnt_d  = stall_cnt_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        id_jump_c    = dec_jump;

        if (bus.flush) begin
            ifid_flush_c = 1'b1;
            id_jump_c    = 1'b0;
        end else if (stall_c) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_ctrl_d    = dec_ctrl;
            ex_illegal_d = dec_illegal;
            ex_rs_d      = bus.id_rs;
            ex_rt_d      = bus.id_rt;
            ex_rd_d      = bus.id_rd;
            ifid_flush_c = dec_jump;
        end

        // While reset is held the front end free-runs; only the jump select tracks decode
        if (reset) begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
            ifid_flush_c = 1'b0;
            id_jump_c    = dec_jump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q    <= '0;
            ex_illegal_q <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_illegal_q <= ex_illegal_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.pc_write      = pc_write_c;
    assign bus.ifid_write    = ifid_write_c;
    assign bus.ifid_flush    = ifid_flush_c;
    assign bus.id_jump       = id_jump_c;

    assign bus.ex_reg_dst    = ex_ctrl_q.reg_dst;
    assign bus.ex_branch     = ex_ctrl_q.branch;
    assign bus.ex_branch_ne  = ex_ctrl_q.branch_ne;
    assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
    assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
    assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
    assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
    assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
    assign bus.ex_illegal    = ex_illegal_q;
    assign bus.ex_rs         = ex_rs_q;
    assign bus.ex_rt         = ex_rt_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule
